bpm_tx_arbiter: RTL and testbench

Packet-atomic round-robin arbiter sharing one Aurora BPM TX AXI stream among up to four packet sources (test-pattern generator, real BPM merge path, diagnostics). Grants one source per packet, never interleaves beats, enforces a per-FA-cycle packet budget per source, and drains sources while the Aurora channel is down. It sits between the packet producers and the Aurora TX core in the Aurora user clock domain.

---
 rtl/bpm_tx_arbiter_pkg.sv | 18 +
 rtl/bpm_tx_arbiter_rrPriorityPick.sv | 38 +++
 rtl/bpm_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bpm_tx_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bpm_tx_arbiter_pkg.sv
// Shared definitions for the BPM TX arbiter and the link arbiters that reuse
// its round-robin picker: state encoding, datapath widths and source limits.
package bpm_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,   // choose a source
        FWD   = 2'd1,   // forward the granted source
        DRAIN = 2'd2,   // discard the rest of the granted packet
        DOWN  = 2'd3    // channel down, sink everything
    } arbState_t;

    localparam int AXI_W     = 32;  // AXI stream data width
    localparam int DROP_W    = 16;  // dropped-beat counter width
    localparam int MAX_SRC   = 4;   // largest supported source count
    localparam int SRC_IDX_W = 2;   // index width covering MAX_SRC sources
    localparam int PKT_CNT_W = 8;   // per-FA packet counter, budget up to 255

endpackage

// File: rtl/bpm_tx_arbiter_rrPriorityPick.sv
// rrPriorityPick: combinational round-robin selector.
// Scans ptr+1, ptr+2, ... modulo N and grants the first set request.
//   req        in   N      request vector
//   ptr        in   IDX_W  index of the last served requester
//   grantOh    out  N      one-hot grant
//   grantIdx   out  IDX_W  index of the granted requester
//   grantValid out  1      any request was granted
module rrPriorityPick
    import bpm_tx_arbiter_pkg::*;
#(
    parameter int N     = MAX_SRC,
    parameter int IDX_W = SRC_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grantOh,
    output logic [IDX_W-1:0] grantIdx,
    output logic             grantValid
);

    always_comb begin
        grantOh    = '0;
        grantIdx   = '0;
        grantValid = 1'b0;
        // Outer loop walks priority order, inner loop matches the rotated
        // position so that all indexing stays on constant loop variables.
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!grantValid && req[j] && (j == (int'(ptr) + k) % N)) begin
                    grantOh[j] = 1'b1;
                    grantIdx   = IDX_W'(j);
                    grantValid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bpm_tx_arbiter.sv
// bpm_tx_arbiter: packet-atomic round-robin arbiter onto one Aurora BPM TX
// AXI stream, with per-FA-cycle packet budget and drain on channel loss.
//   auroraUserClk / auroraUserReset   clock, synchronous active-high reset
//   auroraFAstrobe                    start of FA cycle, clears packet budgets
//   auroraChannelUp                   Aurora channel status
//   SRC_AXI_STREAM_*                  NUM_SRC packed source streams
//   TX_AXI_STREAM_*                   stream to the Aurora TX core
//   dropCount                         saturating count of discarded beats
//   dbgArbState                       current arbiter state
module bpm_tx_arbiter
    import bpm_tx_arbiter_pkg::*;
#(
    parameter int NUM_SRC         = 2,
    parameter int MAX_PKTS_PER_FA = 32
) (
    input  logic                       auroraUserClk,
    input  logic                       auroraUserReset,
    input  logic                       auroraFAstrobe,
    input  logic                       auroraChannelUp,
    input  logic [AXI_W*NUM_SRC-1:0]   SRC_AXI_STREAM_tdata,
    input  logic [NUM_SRC-1:0]         SRC_AXI_STREAM_tvalid,
    input  logic [NUM_SRC-1:0]         SRC_AXI_STREAM_tlast,
    output logic [NUM_SRC-1:0]         SRC_AXI_STREAM_tready,
    output logic [AXI_W-1:0]           TX_AXI_STREAM_tdata,
    output logic                       TX_AXI_STREAM_tvalid,
    output logic                       TX_AXI_STREAM_tlast,
    input  logic                       TX_AXI_STREAM_tready,
    output logic [DROP_W-1:0]          dropCount,
    output logic [1:0]                 dbgArbState
);

    localparam int INC_W = 3;   // holds up to MAX_SRC drops per cycle

    arbState_t                         state, stateNext;
    logic [SRC_IDX_W-1:0]              grant, rrPtr, pickIdx;
    logic [NUM_SRC-1:0]                grantOh, pickOh, pickValidVec;
    logic                              pickValid;
    logic [NUM_SRC-1:0][PKT_CNT_W-1:0] pktCnt;
    logic [NUM_SRC-1:0]                eligible, inPkt, inPktNext, srcHs;
    logic [AXI_W-1:0]                  selData;
    logic                              selValid, selLast;
    logic                              txPktEnd;
    logic [INC_W-1:0]                  dropInc;
    logic [DROP_W:0]                   dropSum;

    assign pickValidVec = {NUM_SRC{pickValid}};

    // Granted-source mux; TX data/last follow it directly (zero latency).
    always_comb begin
        selData  = '0;
        selValid = 1'b0;
        selLast  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == SRC_IDX_W'(i)) begin
                selData  = SRC_AXI_STREAM_tdata[i*AXI_W +: AXI_W];
                selValid = SRC_AXI_STREAM_tvalid[i];
                selLast  = SRC_AXI_STREAM_tlast[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            eligible[i] = SRC_AXI_STREAM_tvalid[i] &&
                          (pktCnt[i] < PKT_CNT_W'(MAX_PKTS_PER_FA));
    end

    rrPriorityPick #(
        .N     (NUM_SRC),
        .IDX_W (SRC_IDX_W)
    ) uPick (
        .req        (eligible),
        .ptr        (rrPtr),
        .grantOh    (pickOh),
        .grantIdx   (pickIdx),
        .grantValid (pickValid)
    );

    assign TX_AXI_STREAM_tdata = selData;
    assign TX_AXI_STREAM_tlast = selLast;
    assign dbgArbState         = state;

    // Outputs. In FWD the channel status gates both sides in the same cycle
    // so a beat offered as the channel falls is neither sent nor consumed;
    // it is then discarded in DRAIN and counted there.
    always_comb begin
        TX_AXI_STREAM_tvalid  = 1'b0;
        SRC_AXI_STREAM_tready = '0;
        dropInc               = '0;
        txPktEnd              = 1'b0;
        case (state)
            FWD: begin
                if (auroraChannelUp) begin
                    TX_AXI_STREAM_tvalid  = selValid;
                    SRC_AXI_STREAM_tready = grantOh & {NUM_SRC{TX_AXI_STREAM_tready}};
                    txPktEnd = selValid && selLast && TX_AXI_STREAM_tready;
                end
            end
            DRAIN: begin
                SRC_AXI_STREAM_tready = grantOh;
                dropInc = INC_W'(selValid);
            end
            DOWN: begin
                SRC_AXI_STREAM_tready = '1;
                for (int i = 0; i < NUM_SRC; i++)
                    dropInc = dropInc + INC_W'(SRC_AXI_STREAM_tvalid[i]);
            end
            default: ;
        endcase
    end

    // Packet framing per source, seen from the source side in every state.
    assign srcHs = SRC_AXI_STREAM_tvalid & SRC_AXI_STREAM_tready;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            inPktNext[i] = srcHs[i] ? !SRC_AXI_STREAM_tlast[i] : inPkt[i];
    end

    // Next state. DOWN looks at inPktNext so a mid-packet beat absorbed this
    // cycle (e.g. the first cycle after reset) keeps the arbiter sinking.
    always_comb begin
        stateNext = state;
        case (state)
            ARB: begin
                if (!auroraChannelUp)  stateNext = DOWN;
                else if (pickValid)    stateNext = FWD;
            end
            FWD: begin
                if (!auroraChannelUp)  stateNext = DRAIN;
                else if (txPktEnd)     stateNext = ARB;
            end
            DRAIN: begin
                if (selValid && selLast) stateNext = DOWN;
            end
            DOWN: begin
                if (auroraChannelUp && (inPktNext == '0)) stateNext = ARB;
            end
            default: stateNext = DOWN;
        endcase
    end

    assign dropSum = {1'b0, dropCount} + (DROP_W+1)'(dropInc);

    always_ff @(posedge auroraUserClk) begin
        if (auroraUserReset) begin
            state     <= DOWN;
            grant     <= '0;
            grantOh   <= NUM_SRC'(1);
            rrPtr     <= SRC_IDX_W'(NUM_SRC - 1);
            pktCnt    <= '0;
            inPkt     <= '0;
            dropCount <= '0;
        end else begin
            state <= stateNext;
            inPkt <= inPktNext;
            if (state == ARB && auroraChannelUp && pickValid) begin
                grant   <= pickIdx;
                grantOh <= pickOh & pickValidVec;
            end
            if (txPktEnd)
                rrPtr <= grant;
            // FA strobe wins over a packet completing in the same cycle.
            if (auroraFAstrobe)
                pktCnt <= '0;
            else if (txPktEnd) begin
                for (int i = 0; i < NUM_SRC; i++)
                    if (grantOh[i]) pktCnt[i] <= pktCnt[i] + PKT_CNT_W'(1);
            end
            dropCount <= dropSum[DROP_W] ? '1 : dropSum[DROP_W-1:0];
        end
    end

endmodule

// File: tb/tb_bpm_tx_arbiter.sv
module tb_bpm_tx_arbiter;
    import bpm_tx_arbiter_pkg::*;

    localparam int NS   = 2;
    localparam int MAXP = 2;

    logic        clk = 1'b0, rst = 1'b1, fa = 1'b0, chUp = 1'b1;
    logic [63:0] sData;
    logic [1:0]  sValid, sLast, sReady;
    logic [31:0] tData;
    logic        tValid, tLast;
    logic        tReady = 1'b1;
    logic [15:0] dropCount;
    logic [1:0]  dbgState;

    always #5 clk = ~clk;

    bpm_tx_arbiter #(.NUM_SRC(NS), .MAX_PKTS_PER_FA(MAXP)) dut (
        .auroraUserClk         (clk),
        .auroraUserReset       (rst),
        .auroraFAstrobe        (fa),
        .auroraChannelUp       (chUp),
        .SRC_AXI_STREAM_tdata  (sData),
        .SRC_AXI_STREAM_tvalid (sValid),
        .SRC_AXI_STREAM_tlast  (sLast),
        .SRC_AXI_STREAM_tready (sReady),
        .TX_AXI_STREAM_tdata   (tData),
        .TX_AXI_STREAM_tvalid  (tValid),
        .TX_AXI_STREAM_tlast   (tLast),
        .TX_AXI_STREAM_tready  (tReady),
        .dropCount             (dropCount),
        .dbgArbState           (dbgState)
    );

    int nTests = 0, nFail = 0, cyc = 0;
    logic [32:0] q0[$], q1[$], expQ[$];   // {last, data}
    bit toggleRdy = 0, gapChk = 0, rdy0Chk = 0, gateChk = 0, postRstChk = 0;
    bit firstBeat = 1;
    int lastEnd = -1, trigBeats = 0, trigAct = 0, faAtLast = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive();
        sValid[0] = q0.size() > 0;
        {sLast[0], sData[31:0]}  = (q0.size() > 0) ? q0[0] : 33'h0;
        sValid[1] = q1.size() > 0;
        {sLast[1], sData[63:32]} = (q1.size() > 0) ? q1[0] : 33'h0;
    endtask

    // Queue an nBeats packet on a source; the first nExp beats are expected on TX.
    task automatic pkt(input int src, input int id, input int nBeats, input int nExp);
        for (int b = 1; b <= nBeats; b++) begin
            logic [32:0] w;
            w = {(b == nBeats), 8'(src), 8'(id), 16'(b)};
            if (src == 0) q0.push_back(w); else q1.push_back(w);
            if (b <= nExp) expQ.push_back(w);
        end
    endtask

    task automatic cycle();
        bit hs0, hs1, fire;
        logic [32:0] e;
        fire = 0;
        @(negedge clk);
        if (tValid && tReady) begin
            e = (expQ.size() > 0) ? expQ.pop_front() : '1;
            chk("txBeat", {tLast, tData}, e);
            if (gapChk && firstBeat && lastEnd >= 0) chk("idleGap", cyc - lastEnd, 2);
            firstBeat = tLast;
            if (tLast) begin
                lastEnd = cyc;
                if (faAtLast > 0) begin
                    faAtLast--;
                    if (faAtLast == 0) fa = 1'b1;
                end
            end
            if (trigBeats > 0) begin
                trigBeats--;
                if (trigBeats == 0) fire = 1;
            end
        end
        if (rdy0Chk) chk("srcRdy0", sReady[0], 0);
        if (gateChk) begin
            chk("dropGateTx", tValid, 0);
            chk("dropGateSrc", sReady[0], 0);
            gateChk = 0;
        end
        if (postRstChk) begin
            chk("rstState", dbgState, 3);
            chk("rstTxValid", tValid, 0);
            chk("rstDrop", dropCount, 0);
            chk("rstRrPtr", dut.rrPtr, NS - 1);
            postRstChk = 0;
        end
        hs0 = sValid[0] && sReady[0];
        hs1 = sValid[1] && sReady[1];
        @(posedge clk);
        #1;
        cyc++;
        fa = 1'b0;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        if (toggleRdy) tReady = ~tReady;
        if (rst) begin
            rst = 1'b0;
            postRstChk = 1;
        end
        if (fire) begin
            if (trigAct == 1) begin chUp = 1'b0; gateChk = 1; end
            else if (trigAct == 2) rst = 1'b1;
        end
        drive();
    endtask

    task automatic runN(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic runUntil(input string tag, input int maxCyc);
        for (int i = 0; i < maxCyc && (expQ.size() + q0.size() + q1.size()) > 0; i++) cycle();
        chk(tag, expQ.size() + q0.size() + q1.size(), 0);
    endtask

    task automatic pulseFa();
        fa = 1'b1;
        cycle();
    endtask

    initial begin
        drive();
        runN(3);                          // reset release + reset-state checks

        // Alternating round robin, 3-beat packets, one idle cycle between.
        pulseFa();
        pkt(0, 1, 3, 3); pkt(1, 1, 3, 3); pkt(0, 2, 3, 3); pkt(1, 2, 3, 3);
        drive();
        lastEnd = -1; firstBeat = 1; gapChk = 1;
        runUntil("rrDone", 60);
        gapChk = 0;

        // Budget of 2 packets per FA cycle, then idle until the strobe.
        pulseFa();
        pkt(0, 3, 2, 2); pkt(0, 4, 2, 2); pkt(0, 5, 2, 0); pkt(0, 6, 2, 0);
        drive();
        runN(30);
        chk("budgetHold", q0.size(), 4);
        chk("budgetIdle", tValid, 0);
        foreach (q0[i]) expQ.push_back(q0[i]);
        pulseFa();
        runUntil("budgetDone", 40);

        // Strobe coincident with the tlast of packet 2 clears the counter.
        pulseFa();
        pkt(0, 7, 2, 2); pkt(0, 8, 2, 2); pkt(0, 9, 2, 2); pkt(0, 10, 2, 2); pkt(0, 11, 2, 0);
        drive();
        faAtLast = 2;
        runN(40);
        chk("faOnLastHold", q0.size(), 2);
        foreach (q0[i]) expQ.push_back(q0[i]);
        pulseFa();
        runUntil("faOnLastDone", 20);

        // Stalling TX on a 4-beat packet from source 1.
        pulseFa();
        pkt(1, 12, 4, 4);
        drive();
        rdy0Chk = 1; toggleRdy = 1;
        runUntil("stallDone", 40);
        rdy0Chk = 0; toggleRdy = 0; tReady = 1'b1;
        runN(2);

        // Channel drops after beat 2 of 5; beats 3..5 are drained.
        rst = 1'b1;
        runN(3);
        pulseFa();
        pkt(0, 13, 5, 2);
        drive();
        trigAct = 1; trigBeats = 2;
        runN(15);
        chk("drainEmpty", q0.size(), 0);
        chk("drainCount", dropCount, 3);
        chk("drainDown", dbgState, 3);
        chUp = 1'b1;
        for (int i = 0; i < 10 && dbgState != 2'd0; i++) cycle();
        chk("upArb", dbgState, 0);
        pkt(0, 14, 3, 3);
        drive();
        runUntil("upDone", 30);

        // Reset mid-packet: beats 1..3 go out, 4..5 are drained after reset.
        pulseFa();
        pkt(0, 15, 5, 3);
        drive();
        trigAct = 2; trigBeats = 2;
        runN(12);
        chk("rstDrainEmpty", q0.size(), 0);
        chk("rstDrainCount", dropCount, 2);
        chk("rstBackArb", dbgState, 0);
        chk("expEmpty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d tests run", nTests);
        $fatal(1);
    end

endmodule
